// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: opening flag, zero-stuffed payload, optional
// zero-stuffed CRC-16 FCS and closing flag, one bit per clock, LSB first.
// Also sends the abort pattern and pulses completion/abort status.
module hdlc_tx_framer #(
  parameter int FCS_EN    = 1,
  parameter int MAX_BYTES = 126
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_DataAvail,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_AbortFrame,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  localparam int         CW        = $clog2(MAX_BYTES + 1);
  localparam logic [7:0] FLAG      = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;

  typedef enum logic [2:0] {IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT} state_t;

  state_t        state_q;
  logic          tx_q, valid_q, done_q, aborted_q;
  logic          rd_q, rd_pend_q;
  logic [7:0]    hold_q, shift_q;
  logic          hold_full_q;
  logic [3:0]    bit_cnt_q;
  logic [2:0]    ones_q;
  logic [15:0]   crc_q;
  logic [CW-1:0] byte_cnt_q;
  logic          fin_done_q, fin_abort_q;
  // Last bit before the closing flag completed a run of five 1s; the
  // stuffed 0 must still go out before the flag starts.
  logic          to_end_q;

  logic          data_bit, fcs_bit, crc_fb, fetch_ok;
  logic [15:0]   crc_d;
  logic [2:0]    ones_d;

  // Next CRC for the payload bit on the shift register, FCS bit select, fetch permission.
  always_comb begin
    data_bit = shift_q[0];
    fcs_bit  = crc_q[bit_cnt_q];
    crc_fb   = crc_q[0] ^ data_bit;
    crc_d    = {1'b0, crc_q[15:1]} ^ (crc_fb ? 16'hA001 : 16'h0000);
    ones_d   = ones_q + 3'd1;
    fetch_ok = Tx_DataAvail && (byte_cnt_q < CW'(MAX_BYTES));
  end

  // Framer FSM: every output is registered and each edge decides the next line bit.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      rd_q        <= 1'b0;
      rd_pend_q   <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 4'd0;
      ones_q      <= 3'd0;
      crc_q       <= 16'h0000;
      byte_cnt_q  <= '0;
      fin_done_q  <= 1'b0;
      fin_abort_q <= 1'b0;
      to_end_q    <= 1'b0;
    end else begin
      rd_q      <= 1'b0;
      rd_pend_q <= rd_q;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      // Buffer data is valid the cycle after the strobe
      if (rd_pend_q) begin
        hold_q      <= Tx_Data;
        hold_full_q <= 1'b1;
      end
      // Refill the holding register once it is empty and nothing is in flight
      if ((state_q == START_FLAG || state_q == DATA) && !hold_full_q &&
          !rd_q && !rd_pend_q && fetch_ok) begin
        rd_q       <= 1'b1;
        byte_cnt_q <= byte_cnt_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          tx_q        <= 1'b1;
          valid_q     <= 1'b0;
          done_q      <= fin_done_q;
          aborted_q   <= fin_abort_q;
          fin_done_q  <= 1'b0;
          fin_abort_q <= 1'b0;
          // A new frame is not taken while the status pulse is still pending
          if (Tx_Enable && !fin_done_q && !fin_abort_q) begin
            state_q     <= START_FLAG;
            crc_q       <= 16'h0000;
            bit_cnt_q   <= 4'd0;
            ones_q      <= 3'd0;
            hold_full_q <= 1'b0;
            to_end_q    <= 1'b0;
            rd_q        <= Tx_DataAvail;
            byte_cnt_q  <= Tx_DataAvail ? CW'(1) : '0;
          end
        end

        START_FLAG, DATA, FCS: begin
          valid_q <= 1'b1;
          if (Tx_AbortFrame) begin
            state_q   <= ABORT;
            tx_q      <= ABORT_PAT[0];
            valid_q   <= 1'b0;
            bit_cnt_q <= 4'd1;
            ones_q    <= 3'd0;
            to_end_q  <= 1'b0;
          end else if (state_q == START_FLAG) begin
            tx_q   <= FLAG[bit_cnt_q[2:0]];
            ones_q <= 3'd0;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= 4'd0;
              if (hold_full_q) begin
                state_q     <= DATA;
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
              end else begin
                state_q <= (FCS_EN != 0) ? FCS : END_FLAG;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (ones_q == 3'd5) begin
            // Inserted zero: no bit count or CRC advance
            tx_q   <= 1'b0;
            ones_q <= 3'd0;
            if (to_end_q) begin
              state_q  <= END_FLAG;
              to_end_q <= 1'b0;
            end
          end else if (state_q == DATA) begin
            tx_q    <= data_bit;
            ones_q  <= data_bit ? ones_d : 3'd0;
            crc_q   <= crc_d;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= 4'd0;
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
              end else if (FCS_EN != 0) begin
                state_q <= FCS;
              end else if (data_bit && ones_q == 3'd4) begin
                to_end_q <= 1'b1;
              end else begin
                state_q <= END_FLAG;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            tx_q   <= fcs_bit;
            ones_q <= fcs_bit ? ones_d : 3'd0;
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_q <= 4'd0;
              if (fcs_bit && ones_q == 3'd4) to_end_q <= 1'b1;
              else                           state_q  <= END_FLAG;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end

        END_FLAG: begin
          tx_q    <= FLAG[bit_cnt_q[2:0]];
          valid_q <= 1'b1;
          ones_q  <= 3'd0;
          if (bit_cnt_q == 4'd7) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            fin_done_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end

        ABORT: begin
          tx_q    <= ABORT_PAT[bit_cnt_q[2:0]];
          valid_q <= 1'b0;
          if (bit_cnt_q == 4'd7) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            fin_abort_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign Tx_RdBuff       = rd_q;
  assign Tx              = tx_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: bit streams, status pulses, buffer reads.
module tb_hdlc_tx_framer;

  logic       Clk, Rst, Tx_Enable, Tx_DataAvail, Tx_AbortFrame;
  logic [7:0] Tx_Data;
  logic       Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans;

  hdlc_tx_framer #(.FCS_EN(1), .MAX_BYTES(126)) dut (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_DataAvail(Tx_DataAvail),
    .Tx_Data(Tx_Data), .Tx_AbortFrame(Tx_AbortFrame), .Tx_RdBuff(Tx_RdBuff),
    .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame), .Tx_Done(Tx_Done),
    .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Tx buffer model: data appears the cycle after the read strobe
  logic [7:0] buf_mem [0:255];
  int buf_len = 0, rd_ptr = 0, rd_count = 0;

  always @(negedge Clk) begin
    if (Rst && Tx_RdBuff) begin
      Tx_Data = buf_mem[rd_ptr];
      rd_ptr++;
      rd_count++;
    end
    Tx_DataAvail = (rd_ptr < buf_len);
  end

  task automatic load_buf(input int n, input int seed, input int step);
    for (int i = 0; i < n; i++) buf_mem[i] = 8'((seed + i * step) & 255);
    buf_len      = n;
    rd_ptr       = 0;
    Tx_DataAvail = (n > 0);
  endtask

  // Expected line bits, built from the buffer contents
  logic        exp_q[$];
  logic        cap_tx[$];
  logic        cap_v[$];
  logic [15:0] exp_crc;

  task automatic build_exp(input int n);
    logic [15:0] crc;
    logic        fb;
    logic        bq[$];
    logic [7:0]  flag;
    int          ones;
    flag = 8'h7E;
    crc  = 16'h0000;
    exp_q.delete();
    bq.delete();
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ buf_mem[i][b];
        crc = (crc >> 1) ^ (fb ? 16'hA001 : 16'h0000);
        bq.push_back(buf_mem[i][b]);
      end
    end
    for (int b = 0; b < 16; b++) bq.push_back(crc[b]);
    for (int b = 0; b < 8; b++) exp_q.push_back(flag[b]);
    ones = 0;
    foreach (bq[i]) begin
      exp_q.push_back(bq[i]);
      if (bq[i]) ones++; else ones = 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    for (int b = 0; b < 8; b++) exp_q.push_back(flag[b]);
    exp_crc = crc;
  endtask

  int cyc_pulse, n_done, n_abrt;

  // Start a frame, capture Tx/ValidFrame up to the first status pulse
  task automatic run_frame(input int abort_cyc, input bit abort_with_start, input int budget);
    int cyc;
    cap_tx.delete();
    cap_v.delete();
    n_done = 0; n_abrt = 0; cyc_pulse = -1; rd_count = 0;
    @(negedge Clk);
    Tx_Enable     = 1'b1;
    Tx_AbortFrame = abort_with_start;
    @(negedge Clk);
    Tx_Enable     = 1'b0;
    Tx_AbortFrame = 1'b0;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge Clk);
      cyc++;
      Tx_AbortFrame = (cyc == abort_cyc);
      if (Tx_Done) n_done++;
      if (Tx_AbortedTrans) n_abrt++;
      if ((Tx_Done || Tx_AbortedTrans) && cyc_pulse < 0) cyc_pulse = cyc;
      if (cyc_pulse < 0) begin
        cap_tx.push_back(Tx);
        cap_v.push_back(Tx_ValidFrame);
      end else if (cyc >= cyc_pulse + 4) begin
        break;
      end
    end
    Tx_AbortFrame = 1'b0;
    if (cyc_pulse < 0) chk("frame_timeout", 0, 1);
  endtask

  task automatic cmp_stream(input string tag);
    int first_bad, vbad;
    first_bad = -1;
    vbad = 0;
    chk({tag, "_len"}, cap_tx.size(), exp_q.size());
    for (int i = 0; i < cap_tx.size() && i < exp_q.size(); i++)
      if (cap_tx[i] !== exp_q[i] && first_bad < 0) first_bad = i;
    chk({tag, "_first_bad_bit"}, first_bad, -1);
    $display("frame %s: bits=%0d pulse_cycle=%0d reads=%0d done=%0d aborted=%0d",
             tag, cap_tx.size(), cyc_pulse, rd_count, n_done, n_abrt);
  endtask

  task automatic chk_valid_run(input string tag, input int ones_n, input int zeros_n);
    int vbad;
    vbad = 0;
    for (int i = 0; i < cap_v.size(); i++)
      if (cap_v[i] !== ((i < ones_n) ? 1'b1 : 1'b0)) vbad++;
    chk({tag, "_valid_len"}, cap_v.size(), ones_n + zeros_n);
    chk({tag, "_valid_errs"}, vbad, 0);
  endtask

  initial begin
    logic [8:0]  pay;
    logic [15:0] fcs;
    int          errs;

    Rst = 1'b0; Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_DataAvail = 1'b0; Tx_Data = 8'h00;

    // Reset and quiet idle
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      chk("idle_lines", int'({Tx, Tx_RdBuff, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans}), 16);
    end
    $display("idle: 50 cycles observed");

    // One byte 0x00: flag, 24 zeros, flag; Done 41 cycles after the enable edge
    load_buf(1, 0, 0);
    build_exp(1);
    run_frame(-1, 1'b0, 200);
    cmp_stream("byte00");
    chk("byte00_done_cycle", cyc_pulse, 41);
    chk("byte00_reads", rd_count, 1);
    chk("byte00_done_pulses", n_done, 1);
    chk("byte00_abort_pulses", n_abrt, 0);
    chk_valid_run("byte00", 40, 0);

    // One byte 0xFF, abort raised together with enable (ignored)
    load_buf(1, 255, 0);
    build_exp(1);
    run_frame(-1, 1'b1, 200);
    cmp_stream("byteFF");
    for (int i = 0; i < 9; i++)  pay[i] = (cap_tx.size() > 8 + i)  ? cap_tx[8 + i]  : 1'b0;
    for (int i = 0; i < 16; i++) fcs[i] = (cap_tx.size() > 17 + i) ? cap_tx[17 + i] : 1'b0;
    chk("byteFF_payload_bits", int'(pay), 'h1DF);
    chk("byteFF_fcs", int'(fcs), 'h4040);
    chk("byteFF_model_crc", int'(exp_crc), 'h4040);
    chk("byteFF_done_cycle", cyc_pulse, 42);
    chk("byteFF_done_pulses", n_done, 1);
    chk("byteFF_abort_pulses", n_abrt, 0);

    // Maximum frame: 130 bytes waiting, only 126 read
    load_buf(130, 3, 37);
    build_exp(126);
    run_frame(-1, 1'b0, 3000);
    cmp_stream("max126");
    chk("max126_reads", rd_count, 126);
    chk("max126_done_cycle", cyc_pulse, exp_q.size() + 1);
    chk("max126_done_pulses", n_done, 1);
    chk_valid_run("max126", exp_q.size(), 0);

    // Abort while payload bit 20 is on the line
    load_buf(4, 'h55, 0);
    build_exp(4);
    while (exp_q.size() > 29) void'(exp_q.pop_back());
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(1'b1);
    run_frame(29, 1'b0, 200);
    cmp_stream("abort");
    chk("abort_pulse_cycle", cyc_pulse, 38);
    chk("abort_pulses", n_abrt, 1);
    chk("abort_done_pulses", n_done, 0);
    chk_valid_run("abort", 29, 8);

    // Reset in the middle of DATA, then a clean frame
    load_buf(3, 0, 0);
    @(negedge Clk);
    Tx_Enable = 1'b1;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    repeat (15) @(negedge Clk);
    chk("midrst_valid_before", int'(Tx_ValidFrame), 1);
    Rst = 1'b0;
    @(negedge Clk);
    chk("midrst_tx", int'(Tx), 1);
    chk("midrst_valid", int'(Tx_ValidFrame), 0);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("midrst_idle_tx", int'(Tx), 1);
    load_buf(1, 'hA5, 0);
    build_exp(1);
    run_frame(-1, 1'b0, 200);
    cmp_stream("after_rst");
    chk("after_rst_done_cycle", cyc_pulse, exp_q.size() + 1);
    chk("after_rst_reads", rd_count, 1);
    chk("after_rst_done_pulses", n_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
